uart_bin_packetizer: RTL and testbench
======================================

Name: uart_bin_packetizer

Overview:
- Parametrised successor to the single-bin UART driver: accepts one bin sample per request and packetizes it into 7-bit data bytes (MSB=0) framed by control bytes (MSB=1).
- Bytes are queued in an internal byte FIFO and serialized 8N1 on UART_TX by an integrated transmitter.
- Sits between the vibration-bin producer and the board UART pin.

Parameters:
- DATA_WIDTH, 22, width of i_data; NCHUNK = ceil(DATA_WIDTH/7) data bytes per bin.
- FIFO_DEPTH, 16, byte FIFO entries; power of 2, >= 2.
- CLKS_PER_BIT, 104, sys_clock cycles per UART bit (>= 2).

Ports:
- sys_clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- UART_send  in  1  one-cycle request to send i_data as one bin.
- new_frame  in  1  qualifies UART_send; 1 = bin starts a new frame.
- i_data  in  DATA_WIDTH  bin value, sampled when the request is accepted.
- o_ready  out  1  queue FSM idle; a request is accepted this cycle.
- o_drop  out  1  one-cycle pulse when UART_send arrives while o_ready=0.
- o_busy  out  1  FIFO non-empty or transmitter active.
- UART_TX  out  1  serial output, idle high.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, transmitter idle, UART_TX=1, o_ready=1, o_drop=0, o_busy=0. Assertion mid-packet discards all queued and in-flight bytes; UART_TX returns to 1 immediately.
- Control codes: FRAME_END=0x80, FRAME_START=0x81, BIN_START=0x82, BIN_END=0x83.
- Data bytes:
  - i_data is zero-extended to 7*NCHUNK bits and split into 7-bit chunks.
  - Chunks are emitted most-significant first, each as {1'b0, chunk}.
- Queue FSM states: IDLE, Q_FEND, Q_FSTART, Q_BSTART, Q_DATA, Q_BEND.
  - IDLE: o_ready=1. On UART_send, latch i_data. Next state is Q_FEND if new_frame=1, else Q_BSTART.
  - Q_FEND -> Q_FSTART -> Q_BSTART -> Q_DATA (NCHUNK writes, chunk counter) -> Q_BEND -> IDLE.
  - Each non-IDLE state writes one byte per cycle and advances only when the FIFO is not full. Full stalls the FSM with no byte lost or duplicated.
  - Push and pop in the same cycle on a full FIFO is legal and counts as not full for the push.
- Latency:
  - The first FIFO write occurs on the edge after acceptance.
  - An uncongested bin with new_frame=0 occupies 1+NCHUNK+2 FSM cycles before o_ready returns high.
- UART_send while o_ready=0: the request is ignored, o_drop pulses for 1 cycle, and the latched data is unaffected.
- Transmitter:
  - When idle with the FIFO non-empty, it pops one byte. The start bit appears on UART_TX the cycle after the pop.
  - Frame format: start(0), 8 data bits LSB first, stop(1). Each bit lasts exactly CLKS_PER_BIT cycles (10*CLKS_PER_BIT per byte).
  - The next start bit immediately follows the stop bit if the FIFO is non-empty. No extra idle cycles are allowed beyond the 1-cycle pop.
- o_busy is 1 from the first FIFO write until the stop bit of the last byte completes with the FIFO empty.
- FIFO: pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty detection. Never read when empty, never write when full.

Optional Feature:
- Macro UART_ZERO_SUPPRESS_EN.
- Defined: in Q_DATA, leading all-zero chunks are skipped (no FIFO write, one cycle each). At least the least-significant chunk is always sent, so i_data=0 yields a single 0x00 byte.
- Not defined: exactly NCHUNK data bytes are always sent.

Test Plan:
- Reset: hold reset=0 with random inputs -> UART_TX=1, o_ready=1, o_busy=0, o_drop=0; then release.
- UART_send=1, new_frame=0, i_data=22'h3FFFFF -> UART_TX carries 0x82,0x01,0x7F,0x7F,0x7F,0x83. The first byte bit pattern is 0,0,1,0,0,0,0,0,1,1 with each bit lasting 104 cycles; bytes are back-to-back.
- new_frame=1, i_data=22'h000005 -> 0x80,0x81,0x82,0x00,0x00,0x00,0x05,0x83. With UART_ZERO_SUPPRESS_EN: 0x80,0x81,0x82,0x05,0x83.
- FIFO_DEPTH=2, three back-to-back bins with new_frame=1 -> the FSM stalls on full, all 24 bytes arrive in order with none lost, and o_ready stays low during stalls.
- UART_send pulsed 2 cycles after an accepted request -> o_drop=1 for exactly 1 cycle, and the output stream is unchanged.
- reset=0 asserted during the third data bit of byte 2 -> UART_TX=1 at once, FIFO empty. After release, a new bin is transmitted correctly with no stale bytes.

Source files
------------

// File: rtl/uart_bin_packetizer.sv
// Bin packetizer: framed 7-bit data bytes, byte FIFO, 8N1 UART transmitter.
// Define UART_ZERO_SUPPRESS_EN to skip leading all-zero data chunks.
module uart_bin_packetizer #(
  parameter int DATA_WIDTH   = 22,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  UART_send,
  input  logic                  new_frame,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_drop,
  output logic                  o_busy,
  output logic                  UART_TX
);
  localparam int NCHUNK = (DATA_WIDTH + 6) / 7;
  localparam int SW = 7 * NCHUNK;
  localparam int CW = $clog2(NCHUNK + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE, Q_FEND, Q_FSTART, Q_BSTART, Q_DATA, Q_BEND
  } state_t;

  state_t state, state_n;

  logic [SW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [6:0]    chunk;
  logic          last, skip, step;
  logic          wr_req, push, pop;
  logic          full, empty, can_push;
  logic [7:0]    wr_byte, rd_byte;

  assign chunk = sh[SW-1 -: 7];
  assign last  = cnt == CW'(NCHUNK - 1);

`ifdef UART_ZERO_SUPPRESS_EN
  logic seen;
  assign skip = (state == Q_DATA) && !seen
             && (chunk == 7'd0) && !last;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset)
      seen <= 1'b0;
    else if (state == IDLE)
      seen <= 1'b0;
    else if (push && state == Q_DATA && chunk != 7'd0)
      seen <= 1'b1;
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_n = state;
    wr_req  = 1'b0;
    wr_byte = 8'h00;
    unique case (state)
      IDLE: begin
        if (UART_send)
          state_n = new_frame ? Q_FEND : Q_BSTART;
      end
      Q_FEND: begin
        wr_req  = 1'b1;
        wr_byte = 8'h80;
        if (can_push) state_n = Q_FSTART;
      end
      Q_FSTART: begin
        wr_req  = 1'b1;
        wr_byte = 8'h81;
        if (can_push) state_n = Q_BSTART;
      end
      Q_BSTART: begin
        wr_req  = 1'b1;
        wr_byte = 8'h82;
        if (can_push) state_n = Q_DATA;
      end
      Q_DATA: begin
        wr_req  = !skip;
        wr_byte = {1'b0, chunk};
        if ((skip || can_push) && last) state_n = Q_BEND;
      end
      Q_BEND: begin
        wr_req  = 1'b1;
        wr_byte = 8'h83;
        if (can_push) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign push = wr_req && can_push;
  assign step = (state == Q_DATA) && (skip || push);

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && UART_send) begin
        sh  <= SW'(i_data);
        cnt <= '0;
      end else if (step) begin
        sh  <= sh << 7;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Byte FIFO; the extra pointer bit separates full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;

  assign empty    = wp == rp;
  assign full     = (wp[AW] != rp[AW])
                 && (wp[AW-1:0] == rp[AW-1:0]);
  assign can_push = !full || pop;
  assign rd_byte  = mem[rp[AW-1:0]];

  always_ff @(posedge sys_clock) begin
    if (push) mem[wp[AW-1:0]] <= wr_byte;
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Transmitter reloads in the last stop-bit cycle for gapless bytes.
  logic          active;
  logic [9:0]    frame;
  logic [BW-1:0] ccnt;
  logic [3:0]    bcnt;
  logic          bit_end, frame_end;

  assign bit_end   = ccnt == BW'(CLKS_PER_BIT - 1);
  assign frame_end = active && bit_end && (bcnt == 4'd9);
  assign pop       = !empty && (!active || frame_end);

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      frame  <= '1;
      ccnt   <= '0;
      bcnt   <= '0;
    end else if (pop) begin
      active <= 1'b1;
      frame  <= {1'b1, rd_byte, 1'b0};
      ccnt   <= '0;
      bcnt   <= '0;
    end else if (active) begin
      if (!bit_end) begin
        ccnt <= ccnt + 1'b1;
      end else begin
        ccnt <= '0;
        if (bcnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bcnt  <= bcnt + 1'b1;
          frame <= {1'b1, frame[9:1]};
        end
      end
    end
  end

  assign UART_TX = !active || frame[0];
  assign o_ready = state == IDLE;
  assign o_drop  = UART_send && !o_ready;
  assign o_busy  = !empty || active;
endmodule

// File: tb/tb_uart_bin_packetizer.sv
// Bench for uart_bin_packetizer: two instances (default and shallow/fast),
// serial monitors and a byte-list reference model.
module tb_uart_bin_packetizer;
  localparam int DW   = 22;
  localparam int NCH  = (DW + 6) / 7;
  localparam int CPB0 = 104;
  localparam int CPB1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic send0, nf0, send1, nf1;
  logic [DW-1:0] d0, d1;
  logic rdy0, drop0, busy0, tx0;
  logic rdy1, drop1, busy1, tx1;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_bin_packetizer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .CLKS_PER_BIT(CPB0)
  ) u_dut0 (
    .sys_clock(clk), .reset(rst_n),
    .UART_send(send0), .new_frame(nf0), .i_data(d0),
    .o_ready(rdy0), .o_drop(drop0), .o_busy(busy0),
    .UART_TX(tx0)
  );

  uart_bin_packetizer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(2), .CLKS_PER_BIT(CPB1)
  ) u_dut1 (
    .sys_clock(clk), .reset(rst_n),
    .UART_send(send1), .new_frame(nf1), .i_data(d1),
    .o_ready(rdy1), .o_drop(drop1), .o_busy(busy1),
    .UART_TX(tx1)
  );

  // Strict-timing receivers: every cycle of a bit must match its first.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int CPB = (g == 0) ? CPB0 : CPB1;
    logic line;
    logic [7:0] rxq[$];
    longint st[$];
    int bad = 0;
    assign line = (g == 0) ? tx0 : tx1;
    initial forever begin : rx
      logic [9:0] b;
      logic ab;
      @(negedge clk);
      if (rst_n === 1'b1 && line === 1'b0) begin
        st.push_back(cyc);
        b = '0;
        ab = 1'b0;
        for (int i = 0; i < 10 && !ab; i++) begin
          for (int k = 0; k < CPB && !ab; k++) begin
            if (i != 0 || k != 0) @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
            else if (k == 0) b[i] = line;
            else if (line !== b[i]) bad++;
          end
        end
        if (!ab) begin
          if (b[9] !== 1'b1) bad++;
          rxq.push_back(b[8:1]);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int g);
    return (g == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic busy(input int g);
    return (g == 0) ? busy0 : busy1;
  endfunction

  function automatic int rx_n(input int g);
    return (g == 0) ? g_mon[0].rxq.size() : g_mon[1].rxq.size();
  endfunction

  // Expected byte list of one bin, straight from the framing rules.
  function automatic void model(input int g, input logic nf,
                                input logic [DW-1:0] d);
    logic [7:0] q[$];
    logic [7*NCH-1:0] e;
    logic [6:0] c;
`ifdef UART_ZERO_SUPPRESS_EN
    bit seen = 0;
`endif
    e = '0;
    e[DW-1:0] = d;
    if (nf) begin
      q.push_back(8'h80);
      q.push_back(8'h81);
    end
    q.push_back(8'h82);
    for (int k = NCH - 1; k >= 0; k--) begin
      c = e[7*k +: 7];
`ifdef UART_ZERO_SUPPRESS_EN
      if (c != 0) seen = 1;
      else if (!seen && k != 0) continue;
`endif
      q.push_back({1'b0, c});
    end
    q.push_back(8'h83);
    foreach (q[i]) begin
      if (g == 0) exp0.push_back(q[i]);
      else exp1.push_back(q[i]);
    end
  endfunction

  task automatic send_bin(input int g, input logic nf,
                          input logic [DW-1:0] d);
    int n = 0;
    while (rdy(g) !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", rdy(g), 1);
    if (g == 0) begin send0 = 1'b1; nf0 = nf; d0 = d; end
    else begin send1 = 1'b1; nf1 = nf; d1 = d; end
    model(g, nf, d);
    @(negedge clk);
    if (g == 0) send0 = 1'b0;
    else send1 = 1'b0;
  endtask

  task automatic drain(input int g);
    logic [7:0] e[$];
    logic [7:0] r[$];
    longint s[$];
    int n = 0;
    if (g == 0) e = exp0;
    else e = exp1;
    while ((rx_n(g) < e.size() || busy(g) !== 1'b0) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (g == 0) begin
      r = g_mon[0].rxq; s = g_mon[0].st;
      g_mon[0].rxq.delete(); g_mon[0].st.delete(); exp0.delete();
    end else begin
      r = g_mon[1].rxq; s = g_mon[1].st;
      g_mon[1].rxq.delete(); g_mon[1].st.delete(); exp1.delete();
    end
    chk("rx_count", r.size(), e.size());
    for (int i = 0; i < e.size() && i < r.size(); i++)
      chk("rx_byte", r[i], e[i]);
    if (g == 0)
      for (int i = 1; i < s.size(); i++)
        chk("b2b_gap", 32'(s[i] - s[i-1]), 10 * CPB0);
  endtask

  initial begin
    logic [DW-1:0] d;
    longint c1;
    int n;
    rst_n = 1'b1;
    send0 = 0; nf0 = 0; d0 = '0;
    send1 = 0; nf1 = 0; d1 = '0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      send0 = 1'($urandom); nf0 = 1'($urandom); d0 = DW'($urandom);
      send1 = 1'($urandom); nf1 = 1'($urandom); d1 = DW'($urandom);
    end
    #1;
    chk("rst_tx0", tx0, 1);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_drop0", drop0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_rdy1", rdy1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_drop1", drop1, 0);
    @(negedge clk);
    send0 = 0; send1 = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single bin, no frame: latency, first-write and first-start timing.
    send_bin(0, 1'b0, 22'h3FFFFF);
    c1 = cyc;
    chk("accept_busy", busy0, 0);
    n = 0;
    while (rdy0 !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) chk("first_write_busy", busy0, 1);
    end
    chk("ready_latency", n, NCH + 2);
    chk("start_seen", g_mon[0].st.size() >= 1, 1);
    if (g_mon[0].st.size() >= 1)
      chk("start_latency", 32'(g_mon[0].st[0] - c1), 2);
    drain(0);

    // New frame, with a request dropped two cycles after acceptance.
    send_bin(0, 1'b1, 22'h000005);
    @(negedge clk);
    send0 = 1'b1; nf0 = 1'($urandom); d0 = DW'($urandom);
    #1;
    chk("drop_pulse", drop0, 1);
    chk("drop_ready", rdy0, 0);
    @(negedge clk);
    send0 = 1'b0;
    #1;
    chk("drop_end", drop0, 0);
    drain(0);

    // Shallow FIFO: three framed bins back to back, FSM must stall.
    for (int b = 0; b < 3; b++) begin
      d = DW'($urandom);
      d[DW-1] = 1'b1;
      send_bin(1, 1'b1, d);
      n = 0;
      while (rdy1 !== 1'b1 && n < 2000) begin
        n++;
        @(negedge clk);
      end
      chk("stall_ready_low", n > NCH + 4, 1);
    end
    drain(1);

    // Reset during the third data bit of the second byte.
    d = DW'($urandom);
    send_bin(1, 1'b1, d);
    n = 0;
    while (g_mon[1].st.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("byte2_start", g_mon[1].st.size() >= 2, 1);
    repeat (3 * CPB1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_ready", rdy1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    while (exp1.size() > 1) void'(exp1.pop_back());
    drain(1);
    send_bin(1, 1'b0, DW'($urandom));
    drain(1);

    // Random bins, including an all-zero sample.
    send_bin(1, 1'($urandom), '0);
    for (int b = 0; b < 5; b++) begin
      d = DW'($urandom) >> $urandom_range(0, DW - 1);
      send_bin(1, 1'($urandom), d);
    end
    drain(1);

    chk("bit_shape0", g_mon[0].bad, 0);
    chk("bit_shape1", g_mon[1].bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
